// File: rtl/bcd_time_counter.sv
// bcd_time_counter: BCD hh:mm:ss clock driven by a prescaled 1 s tick.
// The hour and minute fields can be set with mode/inc buttons.
module bcd_time_counter #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] sec_ge,
    output logic [3:0] sec_shi,
    output logic [3:0] min_ge,
    output logic [3:0] min_shi,
    output logic [3:0] hour_ge,
    output logic [3:0] hour_shi,
    output logic [1:0] set_mode,
    output logic       hour_pulse,
    output logic       day_pulse
);
    localparam int CW = $clog2(CLK_HZ);

    typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tick, run_tick, sec_wrap, min_wrap, hour_wrap, set_inc, set_exit;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        return v == lim ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick      = cnt == CW'(CLK_HZ - 1);
    assign run_tick  = state == RUN && tick;
    assign sec_wrap  = {sec_shi, sec_ge} == 8'h59;
    assign min_wrap  = {min_shi, min_ge} == 8'h59;
    assign hour_wrap = {hour_shi, hour_ge} == 8'h23;
    assign set_inc   = inc_btn && !mode_btn;
    assign set_exit  = state == SET_MIN && mode_btn;
    assign set_mode  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= RUN;
            cnt                  <= '0;
            {sec_shi, sec_ge}    <= 8'h00;
            {min_shi, min_ge}    <= 8'h00;
            {hour_shi, hour_ge}  <= 8'h00;
            hour_pulse           <= 1'b0;
            day_pulse            <= 1'b0;
        end else begin
            hour_pulse <= 1'b0;
            day_pulse  <= 1'b0;
            // leaving SET_MIN restarts the second so the first tick is a full period away
            cnt <= (tick || set_exit) ? '0 : cnt + CW'(1);
            if (mode_btn)
                state <= state == RUN ? SET_HOUR : state == SET_HOUR ? SET_MIN : RUN;
            if (run_tick) begin
                {sec_shi, sec_ge} <= bcd_inc({sec_shi, sec_ge}, 8'h59);
                if (sec_wrap)
                    {min_shi, min_ge} <= bcd_inc({min_shi, min_ge}, 8'h59);
                if (sec_wrap && min_wrap) begin
                    {hour_shi, hour_ge} <= bcd_inc({hour_shi, hour_ge}, 8'h23);
                    hour_pulse          <= 1'b1;
                    day_pulse           <= hour_wrap;
                end
            end
            if (state == SET_HOUR && set_inc)
                {hour_shi, hour_ge} <= bcd_inc({hour_shi, hour_ge}, 8'h23);
            if (state == SET_MIN && set_inc)
                {min_shi, min_ge} <= bcd_inc({min_shi, min_ge}, 8'h59);
            if (set_exit)
                {sec_shi, sec_ge} <= 8'h00;
        end
    end
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: randomized and directed stimulus against a seconds-of-day model;
// expected outputs are queued per clock and checked by an independent monitor.
module tb_bcd_time_counter;
    localparam int HZ = 4;

    logic       clk = 1'b0, rst_n = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
    logic [3:0] sec_ge, sec_shi, min_ge, min_shi, hour_ge, hour_shi;
    logic [1:0] set_mode;
    logic       hour_pulse, day_pulse;

    bcd_time_counter #(.CLK_HZ(HZ)) dut (
        .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec_ge(sec_ge), .sec_shi(sec_shi), .min_ge(min_ge), .min_shi(min_shi),
        .hour_ge(hour_ge), .hour_shi(hour_shi), .set_mode(set_mode),
        .hour_pulse(hour_pulse), .day_pulse(day_pulse)
    );

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    int          secs = 0, mode = 0, pre = 0;
    int          hp_seen = 0, dp_seen = 0;
    bit          chk = 1'b0;
    logic [27:0] q[$];
    logic [27:0] exp_v;

    function automatic logic [27:0] pack(input int t, input int m, input bit hp, input bit dp);
        int h, mi, s;
        h  = t / 3600;
        mi = (t / 60) % 60;
        s  = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
                2'(m), hp, dp};
    endfunction

    function automatic logic [23:0] digits();
        return {hour_shi, hour_ge, min_shi, min_ge, sec_shi, sec_ge};
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    // one clock of stimulus; caller is positioned at a falling edge
    task automatic step(input bit m, input bit i);
        bit tk, hp, dp;
        int h, mi;
        mode_btn = m;
        inc_btn  = i;
        hp = 1'b0;
        dp = 1'b0;
        tk  = pre == HZ - 1;
        pre = tk ? 0 : pre + 1;
        if (mode == 0 && tk) begin
            secs = (secs + 1) % 86400;
            hp   = secs % 3600 == 0;
            dp   = secs == 0;
        end
        if (mode == 1 && i && !m) begin
            h    = secs / 3600;
            secs = secs - h * 3600 + ((h + 1) % 24) * 3600;
        end
        if (mode == 2 && i && !m) begin
            mi   = (secs / 60) % 60;
            secs = secs + (((mi + 1) % 60) - mi) * 60;
        end
        if (m) begin
            if (mode == 2) begin
                secs = secs - secs % 60;
                pre  = 0;
            end
            mode = (mode + 1) % 3;
        end
        q.push_back(pack(secs, mode, hp, dp));
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit m, input bit i);
        for (int k = 0; k < n; k++) step(m, i);
    endtask

    // asynchronous reset checked before any clock edge can occur
    task automatic do_reset();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        chk      = 1'b0;
        rst_n    = 1'b0;
        #1;
        cmp("reset_digits", 32'(digits()), 32'h0);
        cmp("reset_mode", 32'(set_mode), 32'h0);
        cmp("reset_pulses", 32'({hour_pulse, day_pulse}), 32'h0);
        secs = 0;
        mode = 0;
        pre  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        chk   = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL underflow no expected entry at %0t", $time);
            end else begin
                exp_v = q.pop_front();
                cmp("cycle", 32'({digits(), set_mode, hour_pulse, day_pulse}), 32'(exp_v));
                hp_seen += int'(hour_pulse);
                dp_seen += int'(day_pulse);
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        hp_seen = 0;
        run(240, 1'b0, 1'b0);
        cmp("run_240", 32'(digits()), 32'h000100);
        cmp("run_no_hp", 32'(hp_seen), 32'd0);

        do_reset();
        step(1'b1, 1'b0);
        run(23, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        run(59, 1'b0, 1'b1);
        hp_seen = 0;
        dp_seen = 0;
        step(1'b1, 1'b0);
        cmp("preset_2359", 32'(digits()), 32'h235900);
        run(250, 1'b0, 1'b0);
        cmp("midnight_time", 32'(digits()), 32'h000002);
        cmp("midnight_hp", 32'(hp_seen), 32'd1);
        cmp("midnight_dp", 32'(dp_seen), 32'd1);

        do_reset();
        hp_seen = 0;
        dp_seen = 0;
        step(1'b1, 1'b0);
        run(25, 1'b0, 1'b1);
        cmp("hour_25_inc", 32'(digits()), 32'h010000);
        step(1'b1, 1'b0);
        run(61, 1'b0, 1'b1);
        cmp("min_61_inc", 32'(digits()), 32'h010100);
        run(100, 1'b0, 1'b0);
        cmp("set_frozen", 32'(digits()), 32'h010100);
        cmp("set_no_pulses", 32'(hp_seen + dp_seen), 32'd0);
        step(1'b1, 1'b0);
        run(3, 1'b0, 1'b0);
        cmp("exit_hold_3", 32'(digits()), 32'h010100);
        step(1'b0, 1'b0);
        cmp("exit_tick_4", 32'(digits()), 32'h010101);

        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        cmp("both_btn_mode", 32'(set_mode), 32'h2);
        cmp("both_btn_hour", 32'(digits()), 32'h010101);
        step(1'b1, 1'b0);

        for (int k = 0; k < 2000; k++)
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);

        do_reset();
        step(1'b1, 1'b0);
        run(12, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        run(34, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        run(224, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        cmp("pre_reset_time", 32'(digits()), 32'h123456);
        cmp("pre_reset_mode", 32'(set_mode), 32'h2);
        do_reset();
        run(8, 1'b0, 1'b0);

        chk = 1'b0;
        cmp("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 SHALL have parameter: CLK_HZ, 50000000, clk cycles per 1 s tick (legal range >= 2).
REQ-002 SHALL have port: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: mode_btn  in  1  debounced single-cycle pulse, advances set mode.
REQ-005 SHALL have port: inc_btn  in  1  debounced single-cycle pulse, increments selected field.
REQ-006 SHALL have ports: sec_ge, sec_shi, min_ge, min_shi, hour_ge, hour_shi  out  4 each  BCD units/tens digits for the 7-segment display stage.
REQ-007 SHALL have port: set_mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN; 11 never driven.
REQ-008 SHALL have port: hour_pulse  out  1  one-cycle strobe on hour rollover.
REQ-009 SHALL have port: day_pulse  out  1  one-cycle strobe on 23:59:59 -> 00:00:00.

Function
REQ-010 Prescaler SHALL count 0..CLK_HZ-1 every cycle, in all states; internal tick asserts for one cycle when count == CLK_HZ-1, then count wraps to 0.
REQ-011 All outputs SHALL be registered; digits update on the clock edge ending the tick cycle (latency 1 cycle from tick).
REQ-012 Digits SHALL hold only BCD 0-9; sec_shi/min_shi 0-5; hour value 00-23.
REQ-013 RUN + tick: sec_ge +1; 9 -> 0 with carry to sec_shi; sec 59 -> 00 with carry to minutes; min 59 -> 00 with carry to hours; hour 23 -> 00.
REQ-014 hour_pulse SHALL assert in the same cycle the digits change from xx:59:59 to (xx+1):00:00, RUN only; day_pulse additionally when hour wraps 23 -> 00.
REQ-015 State machine: RUN -mode_btn-> SET_HOUR -mode_btn-> SET_MIN -mode_btn-> RUN; no other transitions.
REQ-016 In SET_HOUR/SET_MIN ticks SHALL be ignored (time frozen); hour_pulse/day_pulse stay 0.
REQ-017 SET_HOUR + inc_btn: hour +1, 23 -> 00; minutes/seconds unchanged; no day_pulse.
REQ-018 SET_MIN + inc_btn: minute +1, 59 -> 00; no carry into hours; seconds unchanged.
REQ-019 inc_btn in RUN SHALL be ignored.
REQ-020 mode_btn and inc_btn in same cycle: mode transition taken, inc ignored.
REQ-021 Transition SET_MIN -> RUN SHALL clear seconds to 00 and prescaler to 0 in the same edge, so first tick follows CLK_HZ cycles later.
REQ-022 mode_btn coinciding with tick in RUN: state moves to SET_HOUR and that tick's increment still applies.
REQ-023 set_mode SHALL reflect the registered state, changing one edge after mode_btn.

Reset
REQ-024 rst_n low SHALL immediately force: all digits 0 (00:00:00), set_mode 00, prescaler 0, hour_pulse 0, day_pulse 0.
REQ-025 Reset asserted mid-set or mid-carry SHALL abandon the operation; no partial update visible after release.
REQ-026 First tick after reset release SHALL occur CLK_HZ cycles after the first active edge.

Verification (CLK_HZ=4)
REQ-027 Reset release, run 240 cycles -> time 00:01:00, exactly 60 tick updates, no hour_pulse.
REQ-028 Preload via set mode to 23:59, return to RUN, 240 cycles -> 00:00:00 reached, hour_pulse and day_pulse each high exactly 1 cycle at that transition.
REQ-029 SET_HOUR, 25 inc_btn pulses from 00 -> hour 01; SET_MIN, 61 pulses from 00 -> min 01, hour unchanged; no pulses emitted.
REQ-030 Stay in SET_MIN 100 cycles with ticks -> digits constant; exit -> seconds 00, next change exactly 4 cycles later.
REQ-031 mode_btn and inc_btn same cycle in SET_HOUR -> state SET_MIN, hour unchanged.
REQ-032 Assert rst_n low during SET_MIN at 12:34:56 -> outputs 00:00:00, set_mode 00 without waiting for clk.
